alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Multi-cycle controller between instruction fetch, register file, data memory and the shared 8-bit ALU.
//  Accepts opcode bytes, including the 0xCB prefix. Decodes them into ALU op/src/dest/ext/misc.
//  Fetches operands from a register or from (HL) memory, captures the ALU result and flags, and
//  writes them back. Sits in the CPU core beside the ALU; the ALU is instantiated by the core top.
// PARAMETERS
//  A_IDX        3'b111  register index of accumulator A
//  HL_IDX       3'b110  operand index meaning memory at (HL)
//  MEM_TIMEOUT  15      cycles waited for mem_ack before abort (4-bit counter)
// PORTS
//  clk            in   1   system clock
//  rst_n          in   1   async active-low reset
//  instr_valid    in   1   opcode byte valid
//  instr_ready    out  1   sequencer accepts byte (IDLE, CB_WAIT)
//  instr          in   8   opcode byte
//  rf_raddr_a/b   out  3   reg-file read addresses (a=dest, b=src)
//  rf_rdata_a/b   in   8   reg-file read data, combinational
//  rf_we          out  1   reg-file write strobe (1 cycle)
//  rf_waddr       out  3   write address
//  rf_wdata       out  8   write data
//  f_in           in   4   current flags {Z,N,H,C}
//  f_we / f_out   out  1/4 flag write strobe / value
//  mem_req        out  1   (HL) access request, held until mem_ack
//  mem_we         out  1   1=write, 0=read; stable while mem_req
//  mem_wdata      out  8   write data
//  mem_rdata      in   8   read data, valid with mem_ack
//  mem_ack        in   1   access complete
//  alu_op/src/dest out 3   ALU controls; alu_size out 1 (tied 0)
//  alu_ext/misc   out  1   ALU class selects
//  alu_src_data/alu_dest_data  out  8   registered operands
//  alu_flags_in   out  4   F sampled in READ (carry for ADC/SBC/RL/RR/CCF)
//  alu_res/alu_flags  in  16/4   ALU outputs
//  busy / done / illegal / mem_err   out  1   status; last three are 1-cycle pulses
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except instr_ready=1. Async assert, including mid-access: any
//   mem_req is dropped immediately and no write is issued.
//  FSM: IDLE, CB_WAIT, READ, MEM_RD, EXEC, WB, MEM_WR.
//  IDLE, handshake (valid&ready): 0xCB -> CB_WAIT. Legal base op latched -> READ. Other -> illegal
//   pulse, stay IDLE.
//  Legal base: 0x80-0xBF (ext=0,misc=0,op=[5:3],src=[2:0],dest=A_IDX).
//   0x27/2F/37/3F (misc=1, op={0,[4:3]}, src=dest=A_IDX).
//  CB byte (all legal): <0x40: ext=1,misc=0,op=[5:3],src=dest=[2:0].
//   >=0x40: ext=1,misc=1,op={0,[7:6]},src=[5:3] bit number,dest=[2:0].
//  READ: capture rf_rdata into alu_*_data and f_in into alu_flags_in. If the operand index (src for
//   base arith, dest for CB) ==HL_IDX -> MEM_RD, else EXEC.
//  MEM_RD: mem_req=1, mem_we=0. On mem_ack the data replaces the operand -> EXEC. Counter hits
//   MEM_TIMEOUT -> mem_err pulse, IDLE, no writes.
//  EXEC: ALU stable; register alu_res[7:0] and alu_flags -> WB.
//  WB: one cycle. rf_we if result targets a register. f_we unless RES/SET. done=1.
//   A memory-target write goes to MEM_WR instead; done/f_we are asserted on ack.
//  No reg write for CP, BIT, SCF, CCF. Writes to HL_IDX become memory writes.
//  Latency, instr handshake at T: reg operand done at T+3; (HL) read adds ack wait + 1.
//  busy=1 in every state except IDLE/CB_WAIT. instr_valid ignored while busy.
//  mem_ack outside MEM_RD/MEM_WR is ignored. Timeout counter clears on each new mem_req.
// STRUCTURE
//  gb_alu_pkg: op localparams (base/ext/misc/bit-ops), flag masks, state encoding, A_IDX/HL_IDX
//   defaults, CB prefix 8'hCB.
//  Sub-module alu_op_decode: combinational byte+cb_mode -> {legal,op,src,dest,ext,misc,wr_reg,wr_flags}.
//  Sequencer keeps the FSM, operand/result registers and timeout counter.
// TESTING
//  1 A=0x3A,B=0xC6, instr 0x80 -> alu_op=0,src=0,dest=7; T+3 rf_we=1,waddr=7,wdata=res[7:0],f_we=1,done.
//  2 instr 0xB8 (CP B) -> f_we=1, rf_we=0, done at T+3.
//  3 0xCB,0x46, mem_ack after 3 cycles with 0x01 -> mem_we=0; ext=1,misc=1,op=1,src=0,dest=6;
//    f_we only, no mem write.
//  4 0xCB,0xC6 (SET 0,(HL)) -> read, then mem_we=1 with mem_wdata=res[7:0]; f_we=0; done on ack.
//  5 0x00 -> illegal pulse, no strobes. 0xCB,0x06 with no ack -> mem_err after 15 cycles, IDLE.
//  6 rst_n low in EXEC -> outputs 0 immediately; after release instr_ready=1, no stale writes.

Source files
------------

// File: rtl/gb_alu_pkg.sv
// Shared types and constants for the ALU sequencer.
// Opcode classes, flag masks, FSM encoding, decode bundle.
package gb_alu_pkg;

  localparam logic [2:0] DEF_A_IDX       = 3'b111;
  localparam logic [2:0] DEF_HL_IDX      = 3'b110;
  localparam logic [3:0] DEF_MEM_TIMEOUT = 4'd15;
  localparam logic [7:0] CB_PREFIX       = 8'hCB;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_CP  = 3'd7;

  localparam logic [2:0] EXT_RLC  = 3'd0;
  localparam logic [2:0] EXT_RRC  = 3'd1;
  localparam logic [2:0] EXT_RL   = 3'd2;
  localparam logic [2:0] EXT_RR   = 3'd3;
  localparam logic [2:0] EXT_SLA  = 3'd4;
  localparam logic [2:0] EXT_SRA  = 3'd5;
  localparam logic [2:0] EXT_SWAP = 3'd6;
  localparam logic [2:0] EXT_SRL  = 3'd7;

  localparam logic [2:0] MISC_DAA = 3'd0;
  localparam logic [2:0] MISC_CPL = 3'd1;
  localparam logic [2:0] MISC_SCF = 3'd2;
  localparam logic [2:0] MISC_CCF = 3'd3;

  localparam logic [2:0] BOP_BIT = 3'd1;
  localparam logic [2:0] BOP_RES = 3'd2;
  localparam logic [2:0] BOP_SET = 3'd3;

  localparam logic [3:0] FLAG_Z = 4'b1000;
  localparam logic [3:0] FLAG_N = 4'b0100;
  localparam logic [3:0] FLAG_H = 4'b0010;
  localparam logic [3:0] FLAG_C = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CB_WAIT = 3'd1,
    S_READ    = 3'd2,
    S_MEM_RD  = 3'd3,
    S_EXEC    = 3'd4,
    S_WB      = 3'd5,
    S_MEM_WR  = 3'd6
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [2:0] op;
    logic [2:0] src;
    logic [2:0] dest;
    logic       ext;
    logic       misc;
    logic       wr_reg;
    logic       wr_flags;
  } dec_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder.
// Maps a base or CB-prefixed byte onto ALU controls.
module alu_op_decode
  import gb_alu_pkg::*;
#(
  parameter logic [2:0] A_IDX = DEF_A_IDX
) (
  input  logic [7:0] opc,
  input  logic       cb_mode,
  output dec_t       dec
);

  logic [2:0] bop;
  logic [2:0] mop;

  assign bop = {1'b0, opc[7:6]};
  assign mop = {1'b0, opc[4:3]};

  always_comb begin
    dec = '0;
    unique case (1'b1)
      cb_mode && (opc[7:6] == 2'b00): begin
        dec.legal    = 1'b1;
        dec.ext      = 1'b1;
        dec.op       = opc[5:3];
        dec.src      = opc[2:0];
        dec.dest     = opc[2:0];
        dec.wr_reg   = 1'b1;
        dec.wr_flags = 1'b1;
      end
      cb_mode && (opc[7:6] != 2'b00): begin
        dec.legal    = 1'b1;
        dec.ext      = 1'b1;
        dec.misc     = 1'b1;
        dec.op       = bop;
        dec.src      = opc[5:3];
        dec.dest     = opc[2:0];
        dec.wr_reg   = (bop != BOP_BIT);
        dec.wr_flags = (bop == BOP_BIT);
      end
      !cb_mode && (opc[7:6] == 2'b10): begin
        dec.legal    = 1'b1;
        dec.op       = opc[5:3];
        dec.src      = opc[2:0];
        dec.dest     = A_IDX;
        dec.wr_reg   = (opc[5:3] != OP_CP);
        dec.wr_flags = 1'b1;
      end
      !cb_mode && (opc[7:5] == 3'b001)
        && (opc[2:0] == 3'b111): begin
        dec.legal    = 1'b1;
        dec.misc     = 1'b1;
        dec.op       = mop;
        dec.src      = A_IDX;
        dec.dest     = A_IDX;
        dec.wr_reg   = (mop != MISC_SCF)
                    && (mop != MISC_CCF);
        dec.wr_flags = 1'b1;
      end
      default: begin
        dec.legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer: fetch operands, run the ALU,
// write back to the register file, flags or (HL).
module alu_sequencer
  import gb_alu_pkg::*;
#(
  parameter logic [2:0] A_IDX       = DEF_A_IDX,
  parameter logic [2:0] HL_IDX      = DEF_HL_IDX,
  parameter logic [3:0] MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [7:0]  instr,
  output logic [2:0]  rf_raddr_a,
  output logic [2:0]  rf_raddr_b,
  input  logic [7:0]  rf_rdata_a,
  input  logic [7:0]  rf_rdata_b,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [7:0]  rf_wdata,
  input  logic [3:0]  f_in,
  output logic        f_we,
  output logic [3:0]  f_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [2:0]  alu_op,
  output logic [2:0]  alu_src,
  output logic [2:0]  alu_dest,
  output logic        alu_size,
  output logic        alu_ext,
  output logic        alu_misc,
  output logic [7:0]  alu_src_data,
  output logic [7:0]  alu_dest_data,
  output logic [3:0]  alu_flags_in,
  input  logic [15:0] alu_res,
  input  logic [3:0]  alu_flags,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        mem_err
);

  localparam logic [3:0] TMO_LAST = MEM_TIMEOUT - 4'd1;

  state_t     state, state_n;
  dec_t       dec, dec_q;
  logic       cb_mode;
  logic [7:0] src_q, dst_q, res_q;
  logic [3:0] fin_q, flg_q;
  logic [3:0] cnt;
  logic       ill_q;

  logic ld_dec, ld_op, ld_mem, ld_res;
  logic cnt_clr, cnt_inc, ill_set;
  logic [2:0] opnd;
  logic mem_tgt;
  logic unused_bits;

  assign cb_mode = (state == S_CB_WAIT);

  alu_op_decode #(
    .A_IDX(A_IDX)
  ) u_dec (
    .opc    (instr),
    .cb_mode(cb_mode),
    .dec    (dec)
  );

  // CB ops address their operand through dest; base ops through src
  assign opnd    = dec_q.ext ? dec_q.dest : dec_q.src;
  assign mem_tgt = dec_q.wr_reg && (dec_q.dest == HL_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      dec_q <= '0;
      src_q <= '0;
      dst_q <= '0;
      fin_q <= '0;
      res_q <= '0;
      flg_q <= '0;
      cnt   <= '0;
      ill_q <= 1'b0;
    end else begin
      state <= state_n;
      ill_q <= ill_set;
      if (ld_dec) dec_q <= dec;
      if (ld_op) begin
        src_q <= rf_rdata_b;
        dst_q <= rf_rdata_a;
        fin_q <= f_in;
      end
      if (ld_mem) begin
        if (dec_q.ext) begin
          dst_q <= mem_rdata;
          if (!dec_q.misc) src_q <= mem_rdata;
        end else begin
          src_q <= mem_rdata;
        end
      end
      if (ld_res) begin
        res_q <= alu_res[7:0];
        flg_q <= alu_flags;
      end
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 4'd1;
    end
  end

  always_comb begin
    state_n     = state;
    instr_ready = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    rf_we       = 1'b0;
    f_we        = 1'b0;
    done        = 1'b0;
    mem_err     = 1'b0;
    ld_dec      = 1'b0;
    ld_op       = 1'b0;
    ld_mem      = 1'b0;
    ld_res      = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    ill_set     = 1'b0;
    unique case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          if (instr == CB_PREFIX) begin
            state_n = S_CB_WAIT;
          end else if (dec.legal) begin
            ld_dec  = 1'b1;
            state_n = S_READ;
          end else begin
            ill_set = 1'b1;
          end
        end
      end
      S_CB_WAIT: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ld_dec  = 1'b1;
          state_n = S_READ;
        end
      end
      S_READ: begin
        ld_op = 1'b1;
        if (opnd == HL_IDX) begin
          cnt_clr = 1'b1;
          state_n = S_MEM_RD;
        end else begin
          state_n = S_EXEC;
        end
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ld_mem  = 1'b1;
          state_n = S_EXEC;
        end else if (cnt == TMO_LAST) begin
          mem_err = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_EXEC: begin
        ld_res  = 1'b1;
        state_n = S_WB;
      end
      S_WB: begin
        if (mem_tgt) begin
          cnt_clr = 1'b1;
          state_n = S_MEM_WR;
        end else begin
          rf_we   = dec_q.wr_reg;
          f_we    = dec_q.wr_flags;
          done    = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          f_we    = dec_q.wr_flags;
          done    = 1'b1;
          state_n = S_IDLE;
        end else if (cnt == TMO_LAST) begin
          mem_err = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign busy          = !instr_ready;
  assign illegal       = ill_q;
  assign rf_raddr_a    = dec_q.dest;
  assign rf_raddr_b    = dec_q.src;
  assign rf_waddr      = rf_we ? dec_q.dest : 3'd0;
  assign rf_wdata      = rf_we ? res_q : 8'd0;
  assign f_out         = f_we ? flg_q : 4'd0;
  assign mem_wdata     = mem_we ? res_q : 8'd0;
  assign alu_op        = dec_q.op;
  assign alu_src       = dec_q.src;
  assign alu_dest      = dec_q.dest;
  assign alu_ext       = dec_q.ext;
  assign alu_misc      = dec_q.misc;
  assign alu_size      = 1'b0;
  assign alu_src_data  = src_q;
  assign alu_dest_data = dst_q;
  assign alu_flags_in  = fin_q;

  assign unused_bits = ^{alu_res[15:8], dec_q.legal};

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a stub ALU,
// register file and (HL) memory responder.
module tb_alu_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr;
  logic [2:0]  rf_raddr_a, rf_raddr_b;
  logic [7:0]  rf_rdata_a, rf_rdata_b;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [7:0]  rf_wdata;
  logic [3:0]  f_in;
  logic        f_we;
  logic [3:0]  f_out;
  logic        mem_req, mem_we;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [2:0]  alu_op, alu_src, alu_dest;
  logic        alu_size, alu_ext, alu_misc;
  logic [7:0]  alu_src_data, alu_dest_data;
  logic [3:0]  alu_flags_in;
  logic [15:0] alu_res;
  logic [3:0]  alu_flags;
  logic        busy, done, illegal, mem_err;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .f_in(f_in), .f_we(f_we), .f_out(f_out),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .alu_op(alu_op), .alu_src(alu_src), .alu_dest(alu_dest),
    .alu_size(alu_size), .alu_ext(alu_ext), .alu_misc(alu_misc),
    .alu_src_data(alu_src_data), .alu_dest_data(alu_dest_data),
    .alu_flags_in(alu_flags_in),
    .alu_res(alu_res), .alu_flags(alu_flags),
    .busy(busy), .done(done), .illegal(illegal),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // register file, stub ALU: res = dest + src + Cin
  logic [7:0] regs [8];
  logic [8:0] sum9;
  logic [4:0] hsum;
  assign rf_rdata_a = regs[rf_raddr_a];
  assign rf_rdata_b = regs[rf_raddr_b];
  assign sum9 = {1'b0, alu_dest_data} + {1'b0, alu_src_data}
              + {8'd0, alu_flags_in[0]};
  assign hsum = {1'b0, alu_dest_data[3:0]}
              + {1'b0, alu_src_data[3:0]}
              + {4'd0, alu_flags_in[0]};
  assign alu_res   = {8'hEE, sum9[7:0]};
  assign alu_flags = {sum9[7:0] == 8'd0, alu_misc,
                      hsum[4], sum9[8]};

  typedef struct {
    int         kind;
    logic       rf_we;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic       f_we;
    logic [3:0] fout;
    int         edge_n;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mwq[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ack_delay = -1;
  logic [7:0] mem_val = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input logic rw,
                      input logic [2:0] wa,
                      input logic [7:0] wd, input logic fw,
                      input logic [3:0] fo, input int e);
    exp_t x;
    x.kind = k; x.rf_we = rw; x.waddr = wa; x.wdata = wd;
    x.f_we = fw; x.fout = fo; x.edge_n = e;
    sb.push_back(x);
  endtask

  task automatic send(input logic [7:0] b, output int hs);
    @(negedge clk);
    instr = b;
    instr_valid = 1'b1;
    hs = cyc + 1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = 8'h00;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (sb.size() != 0
         || mwq.size() != 0); i++)
      @(negedge clk);
    repeat (2) @(negedge clk);
    chk("drain_events", sb.size(), 0);
    chk("drain_memwr", mwq.size(), 0);
  endtask

  // memory responder
  initial begin
    int wc;
    wc = 0;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) begin
        wc++;
        if (ack_delay >= 0 && wc >= ack_delay) begin
          mem_ack = 1'b1;
          mem_rdata = mem_val;
          wc = 0;
        end
      end else begin
        wc = 0;
      end
    end
  end

  // monitor
  initial begin
    exp_t e;
    int k;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (done || illegal || mem_err) begin
          if (sb.size() == 0) begin
            chk("unexpected_event",
                {29'd0, done, illegal, mem_err}, 0);
          end else begin
            e = sb.pop_front();
            k = done ? 0 : (illegal ? 1 : 2);
            chk("event_kind", k, e.kind);
            if (e.edge_n != 0)
              chk("latency", cyc + 1, e.edge_n);
            chk("rf_we", rf_we, e.rf_we);
            if (e.rf_we) begin
              chk("rf_waddr", rf_waddr, e.waddr);
              chk("rf_wdata", rf_wdata, e.wdata);
            end
            chk("f_we", f_we, e.f_we);
            if (e.f_we) chk("f_out", f_out, e.fout);
          end
        end else if (rf_we || f_we) begin
          chk("stray_strobe", 1, 0);
        end
        if (mem_req && mem_we && mem_ack) begin
          if (mwq.size() == 0)
            chk("unexpected_mem_write", mem_wdata, 0);
          else
            chk("mem_wdata", mem_wdata, mwq.pop_front());
        end
      end
    end
  end

  initial begin
    int hs;
    regs[0] = 8'hC6; regs[1] = 8'h11; regs[2] = 8'h22;
    regs[3] = 8'h33; regs[4] = 8'h44; regs[5] = 8'h55;
    regs[6] = 8'h66; regs[7] = 8'h3A;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = 8'h00;
    f_in = 4'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    send(8'h80, hs);
    push(0, 1, 3'd7, 8'h00, 1, 4'hB, hs + 3);
    chk("t1_alu_op", alu_op, 0);
    chk("t1_alu_src", alu_src, 0);
    chk("t1_alu_dest", alu_dest, 7);
    chk("t1_alu_ext", alu_ext, 0);
    chk("t1_busy", busy, 1);
    drain();

    send(8'hB8, hs);
    push(0, 0, 3'd0, 8'h00, 1, 4'hB, hs + 3);
    drain();
    send(8'h91, hs);
    push(0, 1, 3'd7, 8'h4B, 1, 4'h0, hs + 3);
    drain();
    send(8'h2F, hs);
    push(0, 1, 3'd7, 8'h74, 1, 4'h6, hs + 3);
    drain();
    send(8'h37, hs);
    push(0, 0, 3'd0, 8'h00, 1, 4'h6, hs + 3);
    drain();
    send(8'h27, hs);
    push(0, 1, 3'd7, 8'h74, 1, 4'h6, hs + 3);
    drain();

    ack_delay = 2; mem_val = 8'h05;
    send(8'h86, hs);
    push(0, 1, 3'd7, 8'h3F, 1, 4'h0, 0);
    drain();

    f_in = 4'h1;
    send(8'hCB, hs);
    send(8'h11, hs);
    push(0, 1, 3'd1, 8'h23, 1, 4'h0, hs + 3);
    drain();

    ack_delay = 3; mem_val = 8'h01;
    send(8'hCB, hs);
    send(8'h46, hs);
    push(0, 0, 3'd0, 8'h00, 1, 4'h4, 0);
    chk("t3_alu_op", alu_op, 1);
    chk("t3_alu_ext", alu_ext, 1);
    chk("t3_alu_misc", alu_misc, 1);
    chk("t3_alu_src", alu_src, 0);
    chk("t3_alu_dest", alu_dest, 6);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("t3_mem_req", mem_req, 1);
    chk("t3_mem_we", mem_we, 0);
    drain();

    f_in = 4'h0; ack_delay = 2; mem_val = 8'h10;
    send(8'hCB, hs);
    send(8'hC6, hs);
    push(0, 0, 3'd0, 8'h00, 0, 4'h0, 0);
    mwq.push_back(8'hD6);
    drain();

    send(8'h00, hs);
    push(1, 0, 3'd0, 8'h00, 0, 4'h0, hs + 1);
    drain();
    send(8'hC0, hs);
    push(1, 0, 3'd0, 8'h00, 0, 4'h0, hs + 1);
    drain();
    ack_delay = -1;
    send(8'hCB, hs);
    send(8'h06, hs);
    push(2, 0, 3'd0, 8'h00, 0, 4'h0, hs + 16);
    drain();

    send(8'h80, hs);
    @(posedge clk);
    #2;
    chk("t6_busy_exec", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_ready", instr_ready, 1);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_rf_we", rf_we, 0);
    chk("t6_alu_dest", alu_dest, 0);
    chk("t6_dest_data", alu_dest_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    send(8'hCB, hs);
    send(8'h46, hs);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("t6_mem_req_on", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_mem_req_off", mem_req, 0);
    chk("t6_mem_we_off", mem_we, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    send(8'h80, hs);
    push(0, 1, 3'd7, 8'h00, 1, 4'hB, hs + 3);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
